// File: rtl/minisrc_defs.sv
// Shared Mini SRC definitions: opcode constants, sequencer step encodings and
// per-class execute lengths used by the control unit and its bench.
package minisrc_defs;

    typedef enum logic [3:0] {
        S_F0   = 4'd0,
        S_F1   = 4'd1,
        S_F2   = 4'd2,
        S_F3   = 4'd3,
        S_E0   = 4'd4,
        S_E1   = 4'd5,
        S_E2   = 4'd6,
        S_E3   = 4'd7,
        S_E4   = 4'd8,
        S_E5   = 4'd9,
        S_HALT = 4'd10
    } step_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Final execute step of each instruction class; the step after it is F0.
    function automatic step_t last_step(input logic [4:0] op);
        case (op)
            OP_LD:                         return S_E5;
            OP_ST:                         return S_E4;
            OP_MUL, OP_DIV, OP_BR:         return S_E3;
            OP_NEG, OP_NOT, OP_JAL:        return S_E1;
            OP_JR, OP_IN, OP_OUT,
            OP_MFHI, OP_MFLO:              return S_E0;
            default:                       return S_E2;
        endcase
    endfunction

    // Immediate forms reuse the register-form ALU operation.
    function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
        case (op)
            OP_ANDI: return OP_AND;
            OP_ORI:  return OP_OR;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit.sv
// Mini SRC hard-wired control sequencer: fetch/execute step register plus a
// purely combinational strobe decode from the current step and IR opcode.
module control_unit
    import minisrc_defs::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CONFF,
    input  logic        stop,
    output logic        run,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout_en,
    output logic        IncPC,
    output logic        PC_en,
    output logic        IR_en,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        Cout,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        memRead,
    output logic        memWrite,
    output logic        inPortOut,
    output logic        outPort_en,
    output logic        CONin,
    output logic [4:0]  opcode
);

    step_t      step, nxt;
    logic [4:0] op;
    logic       unused_ir;

    assign op        = IR[31:27];
    assign unused_ir = ^IR[26:0];

    always_ff @(posedge clock) begin
        if (clear) step <= S_F0;
        else       step <= nxt;
    end

    always_comb begin
        nxt = step;
        case (step)
            S_F0:   nxt = stop ? S_HALT : S_F1;
            S_F1:   nxt = S_F2;
            S_F2:   nxt = S_F3;
            S_F3: begin
                if (op == OP_HALT)                    nxt = S_HALT;
                else if (op == OP_NOP || op > OP_HALT) nxt = S_F0;
                else                                  nxt = S_E0;
            end
            S_HALT: nxt = S_HALT;
            default: nxt = (step == last_step(op)) ? S_F0 : step_t'(step + 4'd1);
        endcase
    end

    always_comb begin
        {Gra, Grb, Grc, Rin, Rout, BAout, PCout_en, IncPC, PC_en, IR_en} = '0;
        {Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout, Cout} = '0;
        {MARin, MDRin, MDRout, memRead, memWrite} = '0;
        {inPortOut, outPort_en, CONin} = '0;
        opcode = 5'b00000;
        run    = clear || (step != S_HALT);
        if (!clear) begin
            case (step)
                // A pending stop suppresses the PC increment so HALT leaves PC intact.
                S_F0: if (!stop) begin PCout_en = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
                S_F1: begin Zlowout = 1'b1; PC_en = 1'b1; memRead = 1'b1; end
                S_F2: begin memRead = 1'b1; MDRin = 1'b1; end
                S_F3: begin MDRout = 1'b1; IR_en = 1'b1; end
                S_HALT: ;
                default: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
                        OP_ADDI, OP_ANDI, OP_ORI: begin
                            case (step)
                                S_E0: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                                S_E1: begin
                                    Zin = 1'b1;
                                    if (op inside {OP_ADDI, OP_ANDI, OP_ORI}) begin
                                        Cout   = 1'b1;
                                        opcode = imm_alu_op(op);
                                    end else begin
                                        Grc    = 1'b1;
                                        Rout   = 1'b1;
                                        opcode = op;
                                    end
                                end
                                S_E2: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                                default: ;
                            endcase
                        end
                        OP_NEG, OP_NOT: begin
                            case (step)
                                S_E0: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
                                S_E1: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                                default: ;
                            endcase
                        end
                        OP_MUL, OP_DIV: begin
                            case (step)
                                S_E0: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                                S_E1: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
                                S_E2: begin Zlowout = 1'b1; LOin = 1'b1; end
                                S_E3: begin Zhighout = 1'b1; HIin = 1'b1; end
                                default: ;
                            endcase
                        end
                        OP_LD, OP_LDI, OP_ST: begin
                            case (step)
                                S_E0: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                                S_E1: begin Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD; end
                                S_E2: begin
                                    Zlowout = 1'b1;
                                    if (op == OP_LDI) begin Gra = 1'b1; Rin = 1'b1; end
                                    else MARin = 1'b1;
                                end
                                S_E3: begin
                                    // For st, memRead stays low so the MDR mux takes the bus.
                                    if (op == OP_LD) memRead = 1'b1;
                                    else if (op == OP_ST) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                                end
                                S_E4: begin
                                    if (op == OP_LD) begin memRead = 1'b1; MDRin = 1'b1; end
                                    else if (op == OP_ST) memWrite = 1'b1;
                                end
                                S_E5: if (op == OP_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                                default: ;
                            endcase
                        end
                        OP_BR: begin
                            case (step)
                                S_E0: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                                S_E1: begin PCout_en = 1'b1; Yin = 1'b1; end
                                S_E2: begin Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD; end
                                S_E3: begin Zlowout = 1'b1; PC_en = CONFF; end
                                default: ;
                            endcase
                        end
                        OP_JR: if (step == S_E0) begin Gra = 1'b1; Rout = 1'b1; PC_en = 1'b1; end
                        OP_JAL: begin
                            case (step)
                                S_E0: begin PCout_en = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                                S_E1: begin Gra = 1'b1; Rout = 1'b1; PC_en = 1'b1; end
                                default: ;
                            endcase
                        end
                        OP_IN:   if (step == S_E0) begin inPortOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_OUT:  if (step == S_E0) begin Gra = 1'b1; Rout = 1'b1; outPort_en = 1'b1; end
                        OP_MFHI: if (step == S_E0) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_MFLO: if (step == S_E0) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: ;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks instructions cycle by cycle against
// hand-derived strobe masks, plus reset, stop, halt and clear scenarios.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear, CONFF, stop;
    logic [31:0] IR;
    logic        run, Gra, Grb, Grc, Rin, Rout, BAout, PCout_en, IncPC, PC_en, IR_en;
    logic        Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout, Cout;
    logic        MARin, MDRin, MDRout, memRead, memWrite, inPortOut, outPort_en, CONin;
    logic [4:0]  opcode;
    logic [26:0] ctl;

    int tests = 0;
    int fails = 0;

    control_unit dut (
        .clock(clock), .clear(clear), .IR(IR), .CONFF(CONFF), .stop(stop), .run(run),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout_en(PCout_en), .IncPC(IncPC), .PC_en(PC_en), .IR_en(IR_en),
        .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout), .Cout(Cout),
        .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .memRead(memRead), .memWrite(memWrite),
        .inPortOut(inPortOut), .outPort_en(outPort_en), .CONin(CONin), .opcode(opcode)
    );

    always #5 clock = ~clock;

    assign ctl = {Gra, Grb, Grc, Rin, Rout, BAout, PCout_en, IncPC, PC_en, IR_en,
                  Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout, Cout,
                  MARin, MDRin, MDRout, memRead, memWrite, inPortOut, outPort_en, CONin};

    localparam logic [26:0] C_GRA = 27'd1 << 26, C_GRB = 27'd1 << 25, C_GRC = 27'd1 << 24;
    localparam logic [26:0] C_RIN = 27'd1 << 23, C_ROUT = 27'd1 << 22, C_BAOUT = 27'd1 << 21;
    localparam logic [26:0] C_PCOUT = 27'd1 << 20, C_INCPC = 27'd1 << 19, C_PCEN = 27'd1 << 18;
    localparam logic [26:0] C_IREN = 27'd1 << 17, C_YIN = 27'd1 << 16, C_ZIN = 27'd1 << 15;
    localparam logic [26:0] C_ZHI = 27'd1 << 14, C_ZLO = 27'd1 << 13, C_HIIN = 27'd1 << 12;
    localparam logic [26:0] C_HIOUT = 27'd1 << 11, C_LOIN = 27'd1 << 10, C_LOOUT = 27'd1 << 9;
    localparam logic [26:0] C_COUT = 27'd1 << 8, C_MARIN = 27'd1 << 7, C_MDRIN = 27'd1 << 6;
    localparam logic [26:0] C_MDROUT = 27'd1 << 5, C_MRD = 27'd1 << 4, C_MWR = 27'd1 << 3;
    localparam logic [26:0] C_INOUT = 27'd1 << 2, C_OUTEN = 27'd1 << 1, C_CONIN = 27'd1;

    localparam logic [26:0] M_F0 = C_PCOUT | C_MARIN | C_INCPC | C_ZIN;
    localparam logic [26:0] M_F1 = C_ZLO | C_PCEN | C_MRD;
    localparam logic [26:0] M_F2 = C_MRD | C_MDRIN;
    localparam logic [26:0] M_F3 = C_MDROUT | C_IREN;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        clear = 1'b1; stop = 1'b0; CONFF = 1'b0; IR = 32'h0;
        tick(); tick();
        tests++;
        if (ctl !== 27'd0 || opcode !== 5'd0 || run !== 1'b1) begin
            fails++;
            $display("FAIL reset_hold: ctl=%h op=%b run=%b, expected ctl=0 op=0 run=1", ctl, opcode, run);
        end
        clear = 1'b0;
        #1;
        tests++;
        if (ctl !== M_F0 || run !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: ctl=%h run=%b, expected ctl=%h run=1", ctl, run, M_F0);
        end
    endtask

    task automatic test_add();
        logic [26:0] em [7];
        logic [4:0]  eo [7];
        em = '{M_F0, M_F1, M_F2, M_F3, C_GRB | C_ROUT | C_YIN, C_GRC | C_ROUT | C_ZIN, C_ZLO | C_GRA | C_RIN};
        eo = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0};
        IR = 32'h1A920000;
        for (int k = 0; k < 7; k++) begin
            tests++;
            if (ctl !== em[k] || opcode !== eo[k]) begin
                fails++;
                $display("FAIL add cyc%0d: ctl=%h op=%b, expected ctl=%h op=%b", k, ctl, opcode, em[k], eo[k]);
            end
            tick();
        end
        tests++;
        if (ctl !== M_F0) begin
            fails++;
            $display("FAIL add_return: ctl=%h, expected %h", ctl, M_F0);
        end
    endtask

    task automatic test_imm();
        logic [26:0] em [7];
        logic [4:0]  eo [7];
        em = '{M_F0, M_F1, M_F2, M_F3, C_GRB | C_ROUT | C_YIN, C_COUT | C_ZIN, C_ZLO | C_GRA | C_RIN};
        eo = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00101, 5'd0};
        IR = 32'h68000000;  // andi
        for (int k = 0; k < 7; k++) begin
            tests++;
            if (ctl !== em[k] || opcode !== eo[k]) begin
                fails++;
                $display("FAIL andi cyc%0d: ctl=%h op=%b, expected ctl=%h op=%b", k, ctl, opcode, em[k], eo[k]);
            end
            tick();
        end
    endtask

    task automatic test_ld();
        logic [26:0] em [10];
        logic [4:0]  eo [10];
        em = '{M_F0, M_F1, M_F2, M_F3, C_GRB | C_BAOUT | C_YIN, C_COUT | C_ZIN, C_ZLO | C_MARIN,
               C_MRD, C_MRD | C_MDRIN, C_MDROUT | C_GRA | C_RIN};
        eo = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0, 5'd0, 5'd0};
        IR = 32'h00880010;
        for (int k = 0; k < 10; k++) begin
            tests++;
            if (ctl !== em[k] || opcode !== eo[k]) begin
                fails++;
                $display("FAIL ld cyc%0d: ctl=%h op=%b, expected ctl=%h op=%b", k, ctl, opcode, em[k], eo[k]);
            end
            tick();
        end
        tests++;
        if (ctl !== M_F0) begin
            fails++;
            $display("FAIL ld_return: ctl=%h, expected %h", ctl, M_F0);
        end
    endtask

    task automatic test_br();
        logic [26:0] em [8];
        logic [4:0]  eo [8];
        for (int c = 0; c < 2; c++) begin
            em = '{M_F0, M_F1, M_F2, M_F3, C_GRA | C_ROUT | C_CONIN, C_PCOUT | C_YIN, C_COUT | C_ZIN,
                   C_ZLO | ((c == 1) ? C_PCEN : 27'd0)};
            eo = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0};
            IR = 32'h98000000;
            CONFF = (c == 1);
            for (int k = 0; k < 8; k++) begin
                tests++;
                if (ctl !== em[k] || opcode !== eo[k]) begin
                    fails++;
                    $display("FAIL br conff=%0d cyc%0d: ctl=%h op=%b, expected ctl=%h op=%b",
                             c, k, ctl, opcode, em[k], eo[k]);
                end
                tick();
            end
            tests++;
            if (ctl !== M_F0) begin
                fails++;
                $display("FAIL br_return conff=%0d: ctl=%h, expected %h", c, ctl, M_F0);
            end
        end
        CONFF = 1'b0;
    endtask

    task automatic test_mul();
        logic [26:0] em [8];
        logic [4:0]  eo [8];
        em = '{M_F0, M_F1, M_F2, M_F3, C_GRA | C_ROUT | C_YIN, C_GRB | C_ROUT | C_ZIN,
               C_ZLO | C_LOIN, C_ZHI | C_HIIN};
        eo = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b01111, 5'd0, 5'd0};
        IR = 32'h78000000;
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (ctl !== em[k] || opcode !== eo[k]) begin
                fails++;
                $display("FAIL mul cyc%0d: ctl=%h op=%b, expected ctl=%h op=%b", k, ctl, opcode, em[k], eo[k]);
            end
            tick();
        end
    endtask

    // jal, mfhi, neg, nop, jr: short classes from a compact table.
    task automatic test_short_classes();
        logic [31:0] ir   [5];
        int          len  [5];
        logic [26:0] em   [5][6];
        logic [4:0]  eop  [5];
        ir  = '{32'hA8000000, 32'hC0000000, 32'h88000000, 32'hD0000000, 32'hA0000000};
        len = '{6, 5, 6, 4, 5};
        em[0] = '{M_F0, M_F1, M_F2, M_F3, C_PCOUT | C_GRB | C_RIN, C_GRA | C_ROUT | C_PCEN};
        em[1] = '{M_F0, M_F1, M_F2, M_F3, C_HIOUT | C_GRA | C_RIN, 27'd0};
        em[2] = '{M_F0, M_F1, M_F2, M_F3, C_GRB | C_ROUT | C_ZIN, C_ZLO | C_GRA | C_RIN};
        em[3] = '{M_F0, M_F1, M_F2, M_F3, 27'd0, 27'd0};
        em[4] = '{M_F0, M_F1, M_F2, M_F3, C_GRA | C_ROUT | C_PCEN, 27'd0};
        eop = '{5'd0, 5'd0, 5'b10001, 5'd0, 5'd0};
        for (int i = 0; i < 5; i++) begin
            IR = ir[i];
            for (int k = 0; k < len[i]; k++) begin
                tests++;
                if (ctl !== em[i][k] || opcode !== ((i == 2 && k == 4) ? eop[i] : 5'd0)) begin
                    fails++;
                    $display("FAIL short ir=%h cyc%0d: ctl=%h op=%b, expected ctl=%h",
                             ir[i], k, ctl, opcode, em[i][k]);
                end
                tick();
            end
            tests++;
            if (ctl !== M_F0) begin
                fails++;
                $display("FAIL short_return ir=%h: ctl=%h, expected %h", ir[i], ctl, M_F0);
            end
        end
    endtask

    task automatic test_clear_st();
        logic [26:0] em [8];
        em = '{M_F0, M_F1, M_F2, M_F3, C_GRB | C_BAOUT | C_YIN, C_COUT | C_ZIN, C_ZLO | C_MARIN,
               C_GRA | C_ROUT | C_MDRIN};
        IR = 32'h10000000;
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (ctl !== em[k]) begin
                fails++;
                $display("FAIL st cyc%0d: ctl=%h, expected %h", k, ctl, em[k]);
            end
            if (k < 7) tick();
        end
        clear = 1'b1;
        #1;
        tests++;
        if (ctl !== 27'd0 || run !== 1'b1) begin
            fails++;
            $display("FAIL st_clear_now: ctl=%h run=%b, expected ctl=0 run=1", ctl, run);
        end
        tick();
        tests++;
        if (ctl !== 27'd0 || memWrite !== 1'b0) begin
            fails++;
            $display("FAIL st_clear_hold: ctl=%h memWrite=%b, expected ctl=0 memWrite=0", ctl, memWrite);
        end
        clear = 1'b0;
        #1;
        tests++;
        if (ctl !== M_F0) begin
            fails++;
            $display("FAIL st_clear_release: ctl=%h, expected %h", ctl, M_F0);
        end
    endtask

    task automatic test_stop();
        logic [26:0] em [7];
        em = '{M_F0, M_F1, M_F2, M_F3, C_GRB | C_ROUT | C_YIN, C_GRC | C_ROUT | C_ZIN, C_ZLO | C_GRA | C_RIN};
        IR = 32'h1A920000;
        for (int k = 0; k < 7; k++) begin
            if (k == 4) stop = 1'b1;
            tests++;
            if (ctl !== em[k]) begin
                fails++;
                $display("FAIL stop_add cyc%0d: ctl=%h, expected %h", k, ctl, em[k]);
            end
            tick();
        end
        tests++;
        if (ctl !== 27'd0 || run !== 1'b1) begin
            fails++;
            $display("FAIL stop_f0: ctl=%h run=%b, expected ctl=0 run=1", ctl, run);
        end
        tick();
        stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (ctl !== 27'd0 || run !== 1'b0) begin
                fails++;
                $display("FAIL stop_halted %0d: ctl=%h run=%b, expected ctl=0 run=0", k, ctl, run);
            end
            tick();
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        tests++;
        if (ctl !== M_F0 || run !== 1'b1) begin
            fails++;
            $display("FAIL stop_recover: ctl=%h run=%b, expected ctl=%h run=1", ctl, run, M_F0);
        end
    endtask

    task automatic test_halt();
        logic [26:0] em [4];
        em = '{M_F0, M_F1, M_F2, M_F3};
        IR = 32'hD8000000;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (ctl !== em[k] || run !== 1'b1) begin
                fails++;
                $display("FAIL halt_fetch cyc%0d: ctl=%h run=%b, expected ctl=%h run=1", k, ctl, run, em[k]);
            end
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (ctl !== 27'd0 || opcode !== 5'd0 || run !== 1'b0) begin
                fails++;
                $display("FAIL halt_state %0d: ctl=%h op=%b run=%b, expected all 0", k, ctl, opcode, run);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm();
        test_ld();
        test_br();
        test_mul();
        test_short_classes();
        test_clear_st();
        test_stop();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Mini SRC hard-wired control sequencer. Sits directly upstream of the `miniSRC` datapath: it reads the instruction register and the CON FF, steps a fetch/execute state machine, and drives every datapath, memory and I/O control strobe plus the 5-bit ALU opcode. It replaces testbench-driven control so the processor runs programs from RAM autonomously.

## Interface
Parameters: none. Opcode constants and step encodings come from the shared package.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- clear  input  1  synchronous, active-high reset. Shared with the datapath.
- IR  input  32  instruction register contents. `IR[31:27]` is the opcode.
- CONFF  input  1  branch condition from the CON FF.
- stop  input  1  halt request. Sampled only in F0.
- run  output  1  1 in all states except HALT.
- Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register select/encode controls.
- PCout_en, IncPC, PC_en, IR_en  output  1 each  PC/IR controls.
- Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout, Cout  output  1 each  datapath controls.
- MARin, MDRin, MDRout, memRead, memWrite  output  1 each  memory interface controls.
- inPortOut, outPort_en, CONin  output  1 each  I/O and branch controls.
  - `inPort_en` is not driven here; it stays external.
- opcode  output  5  ALU operation.
  - Valid only while `Zin`=1.
  - `5'b00000` otherwise.

## Operation
- State register `step` takes the values F0–F3, E0–E5 and HALT.
- Outputs are combinational from `step` and `IR`. Any output not listed for a step is 0.

Fetch:
- F0: PCout_en, MARin, IncPC, Zin.
- F1: Zlowout, PC_en, memRead.
- F2: memRead, MDRin.
- F3: MDRout, IR_en.

Execute. Each class returns to F0 after its last step.
- R-type (add, sub, and, or, shr, shra, shl, ror, rol):
  - E0: Grb, Rout, Yin.
  - E1: Grc, Rout, Zin, opcode=`IR[31:27]`.
  - E2: Zlowout, Gra, Rin.
- addi / andi / ori: same as R-type, except E1 uses Cout instead of Grc/Rout.
  - opcode maps to add 00011, and 00101, or 00110 respectively.
- neg / not:
  - E0: Grb, Rout, Zin, opcode=`IR[31:27]`.
  - E1: Zlowout, Gra, Rin.
- mul / div:
  - E0: Gra, Rout, Yin.
  - E1: Grb, Rout, Zin, opcode.
  - E2: Zlowout, LOin.
  - E3: Zhighout, HIin.
- ld / ldi / st common address steps:
  - E0: Grb, BAout, Yin.
  - E1: Cout, Zin, opcode=00011.
- ldi: E2: Zlowout, Gra, Rin.
- ld:
  - E2: Zlowout, MARin.
  - E3: memRead.
  - E4: memRead, MDRin.
  - E5: MDRout, Gra, Rin.
- st:
  - E2: Zlowout, MARin.
  - E3: Gra, Rout, MDRin (memRead=0, so the MDR mux selects the bus).
  - E4: memWrite.
- br:
  - E0: Gra, Rout, CONin.
  - E1: PCout_en, Yin.
  - E2: Cout, Zin, opcode=00011.
  - E3: Zlowout, and PC_en only if CONFF=1.
- jr: E0: Gra, Rout, PC_en.
- jal:
  - E0: PCout_en, Grb, Rin. The link register is the rb field; the assembler encodes 15 there.
  - E1: Gra, Rout, PC_en.
- Single-step instructions (E0 only):
  - in: inPortOut, Gra, Rin.
  - out: Gra, Rout, outPort_en.
  - mfhi: HIout, Gra, Rin.
  - mflo: LOout, Gra, Rin.
- nop (11010) and any undefined opcode: F3 → F0 directly.
- halt (11011): F3 → HALT.
- HALT:
  - All outputs 0, run=0.
  - Left only via clear.

## Timing
Reset:
- While clear=1: every output is 0, including opcode=0 and PC_en=0. run=1.
- On the first edge with clear=1, `step` ← F0.
- The first cycle after release shows the F0 outputs.

Clear mid-instruction:
- Takes effect at the next edge. No partial strobe follows.
- A `st` cleared during E3 never asserts memWrite.

Register capture and memory:
- Datapath registers capture at the edge that ends the step asserting their enable.
- Memory read latency is 1 cycle after the MAR load. F1/E3 cover that wait; F2/E4 latch the data.

Cycle counts, including the 4 fetch cycles:

| Instruction | Cycles |
|---|---|
| R-type, imm | 7 |
| ldi | 7 |
| neg / not | 6 |
| mul / div | 8 |
| ld | 10 |
| st | 9 |
| br | 8 |
| jr | 5 |
| jal | 6 |
| I/O, mfhi / mflo | 5 |
| nop | 4 |

stop:
- Checked only in F0.
- If stop=1 in F0, the next state is HALT and no F0 strobes are asserted that cycle.
- An instruction already in progress always completes.

Strobe rules:
- memRead and memWrite are never high in the same cycle.
- LOin and HIin are never high in the same cycle.
- PC_en in br E3 is gated only by the current CONFF value.

## Structure
Shared package `minisrc_defs`:
- 5-bit opcode constants: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, neg 10001, not 10010, br 10011, jr 10100, jal 10101, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011.
- Step encodings, used by both the RTL and the bench.

Implementation: no sub-module. One sequential `step` register plus one combinational decode block.

## Test plan
- **Reset:** clear=1 for 2 cycles → all outputs 0, run=1. Release → next cycle PCout_en=MARin=IncPC=Zin=1.
- **add R5,R2,R4** (IR=0x1A920000) → E1 has Grc=Rout=Zin=1 with opcode=00011. E2 has Zlowout=Gra=Rin=1. F0 reappears 7 cycles after the previous F0.
- **ld** → memRead=1 in E3 and E4, MDRin=1 only in E4, Gra=Rin=1 in E5. Total 10 cycles; memWrite stays 0 throughout.
- **br with CONFF=0 vs CONFF=1** → PC_en=0 vs PC_en=1 in E3. Both then return to F0.
- **mul** → LOin=1 only in E2, HIin=1 only in E3.
- **halt, stop and clear:**
  - halt (IR=0xD8000000) → run=0 and all outputs 0 indefinitely.
  - stop=1 asserted during an add's E0 → the add completes, then HALT.
  - clear during st E3 → memWrite never asserted; F0 follows release.
